mult_unit: RTL and testbench
============================

Name: mult_unit

Overview:
- Iterative multiply unit with HI/LO result registers in the mMIPS execute stage.
- Sits directly downstream of the ALU controller. Consumes its 6-bit ALUctrl code.
- On the multiply-unsigned code (6'h13), runs a radix-2 shift-add multiply over WIDTH cycles.
- Holds the pipeline stalled while running, then commits the 2*WIDTH-bit product to HI/LO for the mfhi/mflo datapath.

Parameters:
- WIDTH, 32: operand width; the product is 2*WIDTH bits.
- CTRL_MULTU, 6'h13: ALUctrl code that starts an unsigned multiply.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous and active-low: rst==0 at a rising edge resets the block.
- ALUctrl  input  6  operation code from the ALU controller.
- mult_req  input  1  execute-stage instruction valid (qualifies ALUctrl).
- flush  input  1  pipeline flush; aborts a running multiply.
- op_a  input  WIDTH  multiplicand (rs).
- op_b  input  WIDTH  multiplier (rt).
- stall  output  1  freeze request to the pipeline.
- busy  output  1  multiply in progress.
- done  output  1  one-cycle pulse when HI/LO are committed.
- hi  output  WIDTH  HI register (upper product half).
- lo  output  WIDTH  LO register (lower product half).

Behaviour:
- Reset (rst==0 at an edge): state IDLE; hi, lo, count, accumulator = 0; busy = 0, done = 0. stall = 0 while rst==0.
- Reset has priority over every other input, including mid-operation.
- States:
  - IDLE: start condition is mult_req==1, ALUctrl==CTRL_MULTU and flush==0. On start, latch op_a and op_b, clear the accumulator, set count=0, go to RUN. Other codes are ignored.
  - RUN: one iteration per cycle. If the multiplier LSB is 1, add the multiplicand to the upper accumulator half, keeping the carry in a WIDTH+1-bit sum. Then shift the {carry, acc, multiplier} register right by 1 and increment count. When count reaches WIDTH-1, the iteration in that cycle is the last and the state moves to DONE.
  - DONE: for one cycle, hi <= upper product half, lo <= lower product half, done=1, then IDLE.
- Latency: start sampled at edge E0. Iterations run at edges E1..E_WIDTH. HI/LO are written at edge E_WIDTH+1. done is high in the cycle following E_WIDTH+1.
- busy = (state != IDLE).
- stall is combinational: busy OR (start condition true in IDLE). It is also high in the start cycle, so the issuing instruction and its dependants do not advance.
- stall falls in the cycle where done=1.
- Arithmetic is modulo 2^(2*WIDTH) and cannot overflow.
- hi/lo are never partially updated; they change only in DONE or on reset.
- Boundaries:
  - flush in RUN or DONE: return to IDLE next edge, hi/lo unchanged, done stays 0. If the flush coincides with a DONE commit, the flush wins.
  - mult_req with any code while busy: ignored; the pipeline is stalled anyway.
  - Start condition true in the same cycle as done: not possible, because stall held the issuer. If it is forced by the bench, it is ignored until IDLE.
  - Operand of 0 or all-ones: must produce an exact result (see Test Plan).

Optional Feature:
- Macro MULT_SIGNED_EN.
- When defined: ALUctrl code 6'h14 (signed mult) is also accepted as a start condition. Operands are converted to magnitude at latch time and the sign is recorded. The product is two's-complement negated during DONE if the signs differ. Latency is identical.
- When undefined: 6'h14 is treated like any other non-multiply code (ignored, no stall).

Decomposition:
- Shared package mmips_alu_pkg holds:
  - ALUctrl code constants (CTRL_MULTU=6'h13, CTRL_MULT=6'h14, CTRL_AND=6'h0, ...), also used by the ALU controller.
  - State encoding localparams S_IDLE/S_RUN/S_DONE.
- One natural sub-module: mult_datapath, the accumulator/shift register and adder. The parent keeps the FSM, counter and HI/LO registers.

Test Plan:
- Reset mid-multiply: start 7*9, drop rst at cycle 10 -> next cycle busy=0, hi=0, lo=0, stall=0.
- Basic: ALUctrl=6'h13, op_a=7, op_b=9 -> stall high from the issue cycle, hi=0 and lo=63 committed exactly 33 cycles after start, done pulses once.
- Max operands: op_a=op_b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001.
- Non-multiply code: mult_req=1, ALUctrl=6'h2 -> stall=0, busy=0, hi/lo unchanged. Then 0*32'h12345678 -> hi=lo=0 after 33 cycles.
- Flush: start 3*5, flush at cycle 12 -> IDLE next cycle, hi/lo keep prior values (0,63), done never asserts.
- With MULT_SIGNED_EN: ALUctrl=6'h14, op_a=-3 (32'hFFFFFFFD), op_b=5 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFF1. Without the macro, the same stimulus -> no stall, hi/lo unchanged.

Source files
------------

// File: rtl/mmips_alu_pkg.sv
// ---------------------------------------------------------------------------
// mmips_alu_pkg
//   Shared definitions for the mMIPS execute stage. The ALU controller and
//   the multiply unit both pull their ALUctrl code constants from here, so
//   the two ends of the ALUctrl bus can never disagree on an encoding.
//
// Contents:
//   CTRL_*          6-bit ALUctrl operation codes
//   mult_state_t    state encoding of the iterative multiplier
//                   (S_IDLE / S_RUN / S_DONE)
//   is_mult_code()  true for any code that belongs to the multiply unit
// ---------------------------------------------------------------------------
package mmips_alu_pkg;

  // ALUctrl operation codes
  localparam logic [5:0] CTRL_AND   = 6'h00;
  localparam logic [5:0] CTRL_OR    = 6'h01;
  localparam logic [5:0] CTRL_ADD   = 6'h02;
  localparam logic [5:0] CTRL_XOR   = 6'h03;
  localparam logic [5:0] CTRL_NOR   = 6'h04;
  localparam logic [5:0] CTRL_SUB   = 6'h06;
  localparam logic [5:0] CTRL_SLT   = 6'h07;
  localparam logic [5:0] CTRL_SLL   = 6'h08;
  localparam logic [5:0] CTRL_SRL   = 6'h09;
  localparam logic [5:0] CTRL_SRA   = 6'h0A;
  localparam logic [5:0] CTRL_SLTU  = 6'h0B;
  localparam logic [5:0] CTRL_LUI   = 6'h0C;
  localparam logic [5:0] CTRL_MULTU = 6'h13;
  localparam logic [5:0] CTRL_MULT  = 6'h14;

  // Multiplier control states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } mult_state_t;

  // Lets the ALU controller route both multiply flavours to the multiply
  // unit regardless of whether signed support is built in.
  function automatic logic is_mult_code(input logic [5:0] code);
    return (code == CTRL_MULTU) || (code == CTRL_MULT);
  endfunction

endpackage

// File: rtl/mult_unit_if.sv
// ---------------------------------------------------------------------------
// mult_unit_if
//   Execute-stage bundle between the pipeline and the multiply unit.
//
// Signals:
//   ALUctrl   [5:0]   operation code from the ALU controller
//   mult_req          instruction valid, qualifies ALUctrl
//   flush             pipeline flush, aborts a running multiply
//   op_a      [W-1:0] multiplicand (rs)
//   op_b      [W-1:0] multiplier (rt)
//   stall             freeze request back to the pipeline
//   busy              multiply in progress
//   done              one-cycle pulse when HI/LO are committed
//   hi, lo    [W-1:0] HI/LO result registers
//
// Modports:
//   master  pipeline side (drives the request, reads results)
//   slave   multiply unit side
// ---------------------------------------------------------------------------
interface mult_unit_if #(
  parameter int unsigned WIDTH = 32
);

  logic [5:0]       ALUctrl;
  logic             mult_req;
  logic             flush;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output ALUctrl, mult_req, flush, op_a, op_b,
    input  stall, busy, done, hi, lo
  );

  modport slave (
    input  ALUctrl, mult_req, flush, op_a, op_b,
    output stall, busy, done, hi, lo
  );

endinterface

// File: rtl/mult_datapath.sv
// ---------------------------------------------------------------------------
// mult_datapath
//   Radix-2 shift-add core. Holds the multiplicand and a 2*WIDTH-bit
//   register whose upper half is the partial-product accumulator and whose
//   lower half starts as the multiplier and is shifted out one bit per step.
//   After WIDTH steps the register holds the full unsigned product.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-low reset
//   load_i     latch operands, clear accumulator
//   step_i     perform one add/shift iteration
//   mcand_i    multiplicand to latch
//   mplier_i   multiplier to latch
//   prod_o     {accumulator, multiplier} register (product when finished)
// ---------------------------------------------------------------------------
module mult_datapath
  import mmips_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   mcand_i,
  input  logic [WIDTH-1:0]   mplier_i,
  output logic [2*WIDTH-1:0] prod_o
);

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;

  // The current multiplier LSB gates the multiplicand into the adder.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_addend
      assign addend[gi] = mcand_q[gi] & acc_q[0];
    end
  endgenerate

  // One extra bit keeps the carry so it can be shifted into the
  // accumulator MSB rather than lost.
  assign sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};

  always_comb begin
    mcand_d = mcand_q;
    acc_d   = acc_q;
    if (load_i) begin
      mcand_d = mcand_i;
      acc_d   = {{WIDTH{1'b0}}, mplier_i};
    end else if (step_i) begin
      // {carry, acc, multiplier} >> 1; the consumed multiplier LSB drops off
      acc_d = {sum, acc_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mcand_q <= '0;
      acc_q   <= '0;
    end else begin
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
    end
  end

  assign prod_o = acc_q;

endmodule

// File: rtl/mult_unit.sv
// ---------------------------------------------------------------------------
// mult_unit
//   Iterative multiply unit with HI/LO result registers for the mMIPS
//   execute stage. A multiply takes one start cycle, WIDTH iteration cycles
//   and one commit cycle; the pipeline is stalled throughout.
//
// Ports:
//   clk    system clock, all state changes on the rising edge
//   rst    synchronous active-low reset (highest priority)
//   bus    mult_unit_if.slave: ALUctrl, mult_req, flush, op_a, op_b in;
//          stall, busy, done, hi, lo out
//
// Parameters:
//   WIDTH       operand width, product is 2*WIDTH bits
//   CTRL_MULTU  ALUctrl code that starts an unsigned multiply
//
// Build option:
//   MULT_SIGNED_EN  when defined, ALUctrl CTRL_MULT (6'h14) also starts a
//                   multiply that treats the operands as two's complement.
//                   When undefined that code is ignored like any other.
// ---------------------------------------------------------------------------
module mult_unit
  import mmips_alu_pkg::mult_state_t;
  import mmips_alu_pkg::S_IDLE;
  import mmips_alu_pkg::S_RUN;
  import mmips_alu_pkg::S_DONE;
#(
  parameter int unsigned WIDTH      = 32,
  parameter logic [5:0]  CTRL_MULTU = 6'h13
) (
  input  logic      clk,
  input  logic      rst,
  mult_unit_if.slave bus
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned PW = 2 * WIDTH;

  mult_state_t      state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic             start;
  logic             is_signed_op;
  logic             dp_load;
  logic             dp_step;
  logic [WIDTH-1:0] mcand_in;
  logic [WIDTH-1:0] mplier_in;
  logic [PW-1:0]    prod;
  logic [PW-1:0]    result;

  // -------------------------------------------------------------------------
  // Start decode and operand preparation
  // -------------------------------------------------------------------------
`ifdef MULT_SIGNED_EN
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign is_signed_op = (bus.ALUctrl == mmips_alu_pkg::CTRL_MULT);

  // Signed operands are multiplied as magnitudes; the most negative value
  // maps onto itself, which read as unsigned is exactly its magnitude.
  assign a_mag = (is_signed_op && bus.op_a[WIDTH-1]) ? ((~bus.op_a) + WIDTH'(1)) : bus.op_a;
  assign b_mag = (is_signed_op && bus.op_b[WIDTH-1]) ? ((~bus.op_b) + WIDTH'(1)) : bus.op_b;
  assign neg_d = is_signed_op && (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);

  assign mcand_in  = a_mag;
  assign mplier_in = b_mag;

  // Sign of the product is fixed at latch time alongside the operands.
  always_ff @(posedge clk) begin
    if (!rst) begin
      neg_q <= 1'b0;
    end else if (dp_load) begin
      neg_q <= neg_d;
    end
  end

  assign result = neg_q ? ((~prod) + PW'(1)) : prod;
`else
  assign is_signed_op = 1'b0;
  assign mcand_in     = bus.op_a;
  assign mplier_in    = bus.op_b;
  assign result       = prod;
`endif

  assign start = bus.mult_req && !bus.flush &&
                 ((bus.ALUctrl == CTRL_MULTU) || is_signed_op);

  // -------------------------------------------------------------------------
  // Shift-add datapath
  // -------------------------------------------------------------------------
  mult_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk      (clk),
    .rst      (rst),
    .load_i   (dp_load),
    .step_i   (dp_step),
    .mcand_i  (mcand_in),
    .mplier_i (mplier_in),
    .prod_o   (prod)
  );

  // -------------------------------------------------------------------------
  // Control: next state, iteration counter, HI/LO commit
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dp_load = 1'b0;
    dp_step = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          dp_load = 1'b1;
          count_d = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          dp_step = 1'b1;
          count_d = count_q + CW'(1);
          // the iteration performed in this cycle is the last one
          if (count_q == CW'(WIDTH - 1)) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        // a flush arriving with the commit discards the result
        if (!bus.flush) begin
          hi_d   = result[PW-1:WIDTH];
          lo_d   = result[WIDTH-1:0];
          done_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.busy  = (state_q != S_IDLE);

  // Stall also covers the issue cycle so the multiply and its dependants
  // hold in place; it is forced low while reset is asserted.
  assign bus.stall = rst && ((state_q != S_IDLE) || start);

  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

endmodule

// File: tb/tb_mult_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_unit
//   Self-checking bench for mult_unit: a vector table, hand-written abort
//   sequences (flush in RUN, flush during the commit, reset mid-multiply)
//   and randomized operations checked against an arithmetic product model.
//   Define MULT_SIGNED_EN for both bench and RTL to cover signed multiply.
// ---------------------------------------------------------------------------
module tb_mult_unit;
  import mmips_alu_pkg::*;

  localparam int W = 32;

`ifdef MULT_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mult_unit_if #(.WIDTH(W)) bus ();

  mult_unit #(
    .WIDTH      (W),
    .CTRL_MULTU (CTRL_MULTU)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mdl_hi;
  logic [31:0] mdl_lo;

  typedef struct {
    logic [5:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    bit          starts;
    bit          noise;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Which codes start a multiply, straight from the operation list.
  function automatic bit ref_starts(input logic [5:0] code);
    return (code == CTRL_MULTU) || (SIGNED_EN && (code == CTRL_MULT));
  endfunction

  // Full-width product using plain 64-bit arithmetic.
  function automatic logic [63:0] ref_prod(input logic [5:0] code, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa;
    longint sb;
    logic [63:0] ua;
    logic [63:0] ub;
    if (code == CTRL_MULT) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'h0, a};
    ub = {32'h0, b};
    return ua * ub;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h0000_0001;
      default: return 32'($urandom);
    endcase
  endfunction

  // Issue one request and follow it cycle by cycle. c counts edges after
  // the start edge E0: busy for c=0..W, done pulse at c=W+1. An abort at
  // cycle c (flush or rst low during that cycle) takes effect at the next
  // edge. With noise set, further multiply requests are driven mid-run.
  task automatic run_op(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b,
                        input bit starts, input int abort_c, input bit abort_rst,
                        input bit noise, input string tag);
    int       dones;
    int       ncyc;
    bit       live;
    logic [2:0] exp_v;
    dones = 0;
    ncyc  = starts ? W + 4 : 3;

    @(negedge clk);
    rst          = 1'b1;
    bus.flush    = 1'b0;
    bus.ALUctrl  = code;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.mult_req = 1'b1;
    #1;
    check({tag, "_issue_stall"}, 64'(bus.stall), 64'(starts));

    @(negedge clk);
    bus.mult_req = 1'b0;
    bus.ALUctrl  = CTRL_AND;
    for (int c = 0; c < ncyc; c++) begin
      if (noise && c >= 4 && c <= 7) begin
        bus.mult_req = 1'b1;
        bus.ALUctrl  = CTRL_MULTU;
        bus.op_a     = 32'($urandom);
        bus.op_b     = 32'($urandom);
      end else begin
        bus.mult_req = 1'b0;
      end
      rst       = !(abort_rst && c == abort_c);
      bus.flush = !abort_rst && c == abort_c;

      live     = starts && (abort_c < 0 || c <= abort_c);
      exp_v[2] = live && c <= W;
      exp_v[1] = live && c == W + 1;
      exp_v[0] = exp_v[2] && !(abort_rst && c == abort_c);
      #1;
      check($sformatf("%s_c%0d_busy_done_stall", tag, c),
            64'({bus.busy, bus.done, bus.stall}), 64'(exp_v));
      if (bus.done) dones++;
      @(negedge clk);
    end
    rst          = 1'b1;
    bus.flush    = 1'b0;
    bus.mult_req = 1'b0;
    check({tag, "_done_count"}, 64'(dones),
          64'((starts && (abort_c < 0 || abort_c > W)) ? 1 : 0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
    bit          st;

    // ---- table of {inputs, expected HI/LO} ----
    vecs[0] = '{CTRL_MULTU, 32'd7,          32'd9,          1'b1, 1'b0, 32'h0,         32'd63};
    vecs[1] = '{CTRL_ADD,   32'd5,          32'd6,          1'b0, 1'b0, 32'h0,         32'd63};
    vecs[2] = '{CTRL_MULTU, 32'd0,          32'h1234_5678,  1'b1, 1'b0, 32'h0,         32'h0};
    vecs[3] = '{CTRL_MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001};
    if (SIGNED_EN)
      vecs[4] = '{CTRL_MULT, 32'hFFFF_FFFD, 32'd5,          1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    else
      vecs[4] = '{CTRL_MULT, 32'hFFFF_FFFD, 32'd5,          1'b0, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[5] = '{CTRL_MULTU, 32'h8000_0000,  32'd2,          1'b1, 1'b1, 32'h1,         32'h0};
    vecs[6] = '{CTRL_MULTU, 32'hFFFF_FFFF,  32'd1,          1'b1, 1'b0, 32'h0,         32'hFFFF_FFFF};
    vecs[7] = '{CTRL_MULTU, 32'd7,          32'd9,          1'b1, 1'b1, 32'h0,         32'd63};

    // ---- reset, with a start request held active throughout ----
    rst          = 1'b0;
    bus.flush    = 1'b0;
    bus.mult_req = 1'b1;
    bus.ALUctrl  = CTRL_MULTU;
    bus.op_a     = 32'd3;
    bus.op_b     = 32'd3;
    repeat (3) @(negedge clk);
    check("rst_stall", 64'(bus.stall), 64'(0));
    check("rst_busy",  64'(bus.busy),  64'(0));
    check("rst_done",  64'(bus.done),  64'(0));
    check("rst_hi",    64'(bus.hi),    64'(0));
    check("rst_lo",    64'(bus.lo),    64'(0));
    bus.mult_req = 1'b0;
    rst          = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 64'(bus.busy), 64'(0));
    mdl_hi = 32'h0;
    mdl_lo = 32'h0;

    // ---- table-driven vectors ----
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].code, vecs[i].a, vecs[i].b, vecs[i].starts, -1, 1'b0,
             vecs[i].noise, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_hi", i), 64'(bus.hi), 64'(vecs[i].hi));
      check($sformatf("vec%0d_lo", i), 64'(bus.lo), 64'(vecs[i].lo));
    end
    mdl_hi = 32'h0;
    mdl_lo = 32'd63;

    // ---- flush in RUN: HI/LO keep 0/63, no done ----
    run_op(CTRL_MULTU, 32'd3, 32'd5, 1'b1, 12, 1'b0, 1'b0, "flush_run");
    check("flush_run_hi", 64'(bus.hi), 64'(mdl_hi));
    check("flush_run_lo", 64'(bus.lo), 64'(mdl_lo));

    // ---- flush coinciding with the commit cycle: flush wins ----
    run_op(CTRL_MULTU, 32'd2, 32'd3, 1'b1, W, 1'b0, 1'b0, "flush_done");
    check("flush_done_hi", 64'(bus.hi), 64'(mdl_hi));
    check("flush_done_lo", 64'(bus.lo), 64'(mdl_lo));

    // ---- reset mid-multiply: HI/LO cleared ----
    run_op(CTRL_MULTU, 32'd7, 32'd9, 1'b1, 10, 1'b1, 1'b0, "rst_mid");
    mdl_hi = 32'h0;
    mdl_lo = 32'h0;
    check("rst_mid_hi", 64'(bus.hi), 64'(mdl_hi));
    check("rst_mid_lo", 64'(bus.lo), 64'(mdl_lo));

    // ---- randomized operations against the arithmetic model ----
    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: code = CTRL_MULTU;
        3, 4:    code = CTRL_MULT;
        default: code = CTRL_ADD;
      endcase
      a  = pick_operand();
      b  = pick_operand();
      st = ref_starts(code);
      run_op(code, a, b, st, -1, 1'b0, (i % 3) == 0, $sformatf("rnd%0d", i));
      if (st) begin
        p      = ref_prod(code, a, b);
        mdl_hi = p[63:32];
        mdl_lo = p[31:0];
      end
      $display("rnd%0d code=%h a=%h b=%h -> hi=%h lo=%h (model %h %h)",
               i, code, a, b, bus.hi, bus.lo, mdl_hi, mdl_lo);
      check($sformatf("rnd%0d_hi", i), 64'(bus.hi), 64'(mdl_hi));
      check($sformatf("rnd%0d_lo", i), 64'(bus.lo), 64'(mdl_lo));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
